// File: rtl/hfu_pkg.sv
// Shared constants for the hazard/forwarding unit: EX mux select codes and
// stall cause encodings.
package hfu_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_LOAD_USE = 2'd1,
    CAUSE_BR_ALU   = 2'd2,
    CAUSE_BR_LOAD  = 2'd3
  } stall_cause_e;

endpackage

// File: rtl/hfu_src_match.sv
// Compares one ID-stage source operand against the EX/MEM/WB destinations.
// Register 0 and unused operands never match.
module hfu_src_match
  import hfu_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic          src_used,
  input  logic [AW-1:0] ex_dst,
  input  logic [AW-1:0] mem_dst,
  input  logic [AW-1:0] wb_dst,
  input  logic          ex_regwrite,
  input  logic          mem_regwrite,
  input  logic          wb_regwrite,
  output logic          ex_hit,
  output logic          mem_hit,
  output logic          wb_hit
);

  logic src_live;

  assign src_live = src_used && (src != '0);
  assign ex_hit   = src_live && ex_regwrite  && (ex_dst  == src);
  assign mem_hit  = src_live && mem_regwrite && (mem_dst == src);
  assign wb_hit   = src_live && wb_regwrite  && (wb_dst  == src);

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding and hazard detection for a 5-stage pipeline: registered
// EX forward selects, ID branch-compare forwarding, stall generation and a
// saturating stall-cycle counter.
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]     id_src_used,
  input  logic                   id_branch,
  input  logic [AW-1:0]          ex_dst,
  input  logic [AW-1:0]          mem_dst,
  input  logic [AW-1:0]          wb_dst,
  input  logic                   ex_regwrite,
  input  logic                   mem_regwrite,
  input  logic                   wb_regwrite,
  input  logic                   ex_memread,
  input  logic                   mem_memread,
  input  logic                   ext_stall,
  input  logic                   clr_cnt,
  output logic [NUM_SRC*2-1:0]   ex_fwd_sel,
  output logic [NUM_SRC-1:0]     id_fwd_sel,
  output logic                   stall,
  output logic [1:0]             stall_cause,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_SRC-1:0]    ex_hit;
  logic [NUM_SRC-1:0]    mem_hit;
  logic [NUM_SRC-1:0]    wb_hit;
  logic [NUM_SRC*2-1:0]  fwd_calc;
  logic                  any_ex_hit;
  logic                  any_mem_hit;
  stall_cause_e          cause;
  logic                  stall_int;
  logic [NUM_SRC*2-1:0]  ex_fwd_sel_d, ex_fwd_sel_q;
  logic [CNT_W-1:0]      stall_cycles_d, stall_cycles_q;
  logic                  unused_wb_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      hfu_src_match #(.AW(AW)) u_match (
        .src          (id_src[gi*AW +: AW]),
        .src_used     (id_src_used[gi]),
        .ex_dst       (ex_dst),
        .mem_dst      (mem_dst),
        .wb_dst       (wb_dst),
        .ex_regwrite  (ex_regwrite),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .ex_hit       (ex_hit[gi]),
        .mem_hit      (mem_hit[gi]),
        .wb_hit       (wb_hit[gi])
      );

      // The EX producer is younger than the MEM one, so it wins.
      assign fwd_calc[gi*2 +: 2] = ex_hit[gi]  ? FWD_MEM :
                                   mem_hit[gi] ? FWD_WB  : FWD_RF;
    end
  endgenerate

  // The register file writes before it reads, so WB hits need no action.
  assign unused_wb_hit = |wb_hit;

  assign any_ex_hit  = |ex_hit;
  assign any_mem_hit = |mem_hit;

  always_comb begin
    cause = CAUSE_NONE;
    if (ex_memread && any_ex_hit) begin
      cause = CAUSE_LOAD_USE;
    end else if (id_branch && any_ex_hit) begin
      cause = CAUSE_BR_ALU;
    end else if (id_branch && any_mem_hit && mem_memread) begin
      cause = CAUSE_BR_LOAD;
    end
  end

  assign stall_int = (cause != CAUSE_NONE) && !ext_stall;

  always_comb begin
    ex_fwd_sel_d = ex_fwd_sel_q;
    if (!ext_stall) begin
      ex_fwd_sel_d = stall_int ? '0 : fwd_calc;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (clr_cnt) begin
      stall_cycles_d = '0;
    end else if (stall_int && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_fwd_sel_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      ex_fwd_sel_q   <= ex_fwd_sel_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Combinational outputs are masked while reset is held.
  assign stall        = rst_n && stall_int;
  assign stall_cause  = rst_n ? cause : CAUSE_NONE;
  assign id_fwd_sel   = (rst_n && id_branch && !mem_memread) ? mem_hit : '0;
  assign ex_fwd_sel   = ex_fwd_sel_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard-detection unit for the 5-stage pipelined datapath (IF/ID/EX/MEM/WB). It generalises operand forwarding to NUM_SRC source operands and configurable register-address width. It adds three things: load-use and ID-stage branch hazard stalls, branch-compare forwarding in ID, and a saturating stall-cycle counter. Forward selects are precomputed from ID-stage fields and registered at the ID→EX posedge, so the EX-stage muxes receive a stable select for the whole EX cycle.

## Interface
- AW, 5: register address width
- NUM_SRC, 2: source operands per instruction (rs, rt, ...)
- CNT_W, 16: stall counter width

- clk  in  1  pipeline clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- id_src  in  NUM_SRC*AW  ID-stage source addresses; operand i is at [i*AW +: AW]
- id_src_used  in  NUM_SRC  operand i is actually read
- id_branch  in  1  ID-stage instruction is a branch compared in ID
- ex_dst, mem_dst, wb_dst  in  AW each  destination register per stage
- ex_regwrite, mem_regwrite, wb_regwrite  in  1 each  stage writes the register file
- ex_memread, mem_memread  in  1 each  stage instruction is a load
- ext_stall  in  1  global freeze (memory wait)
- clr_cnt  in  1  synchronous clear of stall_cycles
- ex_fwd_sel  out  NUM_SRC*2  registered EX mux select per operand: 0 RF, 1 MEM, 2 WB
- id_fwd_sel  out  NUM_SRC  combinational ID branch-compare select: 0 RF, 1 MEM ALU result
- stall  out  1  combinational; hold PC and IF/ID, bubble into ID/EX
- stall_cause  out  2  0 none, 1 load-use, 2 branch-on-ALU, 3 branch-on-load
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- Match rule for operand i: id_src_used[i], src≠0, the stage's regwrite=1, and the stage's dst equals src. Register 0 is never forwarded and never causes a stall.
- Hazards are evaluated combinationally. Priority when several apply:
  - Load-use: ex_memread and an EX match → cause 1.
  - Branch-on-ALU: id_branch and an EX match with ex_memread=0 → cause 2.
  - Branch-on-load: id_branch and a MEM match with mem_memread=1 → cause 3.
- stall = (cause≠0) & !ext_stall.
- id_fwd_sel[i] = 1 when id_branch, there is a MEM match, and mem_memread=0. Otherwise 0.
- The register file is write-before-read, so ID never needs a WB forward.
- ex_fwd_sel update at posedge:
  - ext_stall=1: hold.
  - Else stall=1: all zeros (a bubble enters EX).
  - Else per operand: 1 if EX match; else 2 if MEM match; else 0. The EX match has priority because it is the younger producer.
- stall_cycles at posedge:
  - clr_cnt=1: 0. Clear wins over increment and over ext_stall.
  - Else stall=1 and not all-ones: +1.
  - Otherwise hold.

## Timing
- Reset (rst_n low, asynchronous): ex_fwd_sel=0 and stall_cycles=0. stall, stall_cause and id_fwd_sel are forced 0 while rst_n is low.
- Forward latency: the select computed in cycle n is valid for the whole of cycle n+1, when that instruction is in EX.
- Stall lengths:
  - Load-use stalls exactly 1 cycle. The load then sits in MEM, and ex_fwd_sel selects WB on the next update.
  - Branch-on-ALU stalls 1 cycle, then id_fwd_sel=1.
  - Branch-on-load stalls 2 cycles: cause 1 then cause 3 for a load in EX, or 1 cycle of cause 3 if the load is already in MEM.
- ext_stall asserted mid-stall: state freezes, and stall_cause stays visible while stall=0. Once ext_stall drops, the hazard is re-evaluated with identical inputs, so the stall resumes.
- Reset mid-stall: all outputs go to 0 immediately, and no residual stall is produced after release.
- Counter saturation: stall_cycles stays at 2^CNT_W−1.

## Structure
- Package hfu_pkg holds the constants FWD_RF=0, FWD_MEM=1, FWD_WB=2 and the stall_cause encodings CAUSE_NONE, CAUSE_LOAD_USE, CAUSE_BR_ALU, CAUSE_BR_LOAD.
- Sub-module hfu_src_match: one AW-wide operand compared against the EX/MEM/WB destinations, producing ex_hit, mem_hit and wb_hit. The top instantiates it NUM_SRC times in a generate loop, then ORs the hits into the hazard logic.

## Test plan
- EX instruction "add r3" (ex_dst=3, regwrite), ID instruction reads r3 on src0 → next cycle ex_fwd_sel[1:0]=1. Same read with only MEM writing r3 → 2. Both EX and MEM writing r3 → 1.
- ex_memread=1, ex_dst=5, ID src1=5 → stall=1, cause=1 for exactly 1 cycle; ex_fwd_sel=0 that update, then [3:2]=2.
- id_branch with src0 = ex_dst = 7 (ALU) → 1 stall cycle, cause 2, then id_fwd_sel[0]=1. A load to r7 in EX → 2 stall cycles (cause 1, then 3).
- Writes to r0 in any stage with matching sources → no stall, all selects 0.
- ext_stall held 3 cycles during a load-use → stall=0, ex_fwd_sel and stall_cycles unchanged; after release the stall occurs once and stall_cycles increments by 1.
- Preload stall_cycles to all-ones (CNT_W=4) → it holds at 15. clr_cnt together with stall → 0. rst_n pulsed low mid-stall → all outputs 0 asynchronously.
